// File: rtl/ft_bus_arbiter.sv
// rtl/ft_bus_arbiter.sv - FT601 shared-bus burst scheduler between the A2F write path and F2A read path
module ft_bus_arbiter #(
    parameter int FT_DATA_WIDTH = 32,
    parameter int BURST_WORDS   = 32,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     ft_txe_n,
    input  logic                     ft_rxf_n,
    output logic                     ft_oe_n,
    output logic                     ft_wr_n,
    output logic                     ft_rd_n,
    input  logic [FT_DATA_WIDTH-1:0] ft_data_in,
    output logic [FT_DATA_WIDTH-1:0] ft_data_out,
    output logic [3:0]               ft_be_out,
    output logic                     ft_bus_oe,
    input  logic [FT_DATA_WIDTH-1:0] a2f_data,
    input  logic [CNT_WIDTH-1:0]     a2f_count,
    output logic                     a2f_rd_en,
    output logic [FT_DATA_WIDTH-1:0] f2a_data,
    output logic                     f2a_wr_en,
    input  logic [CNT_WIDTH-1:0]     f2a_free,
    output logic                     busy,
    output logic                     dir_wr
);

    localparam int WC_W = $clog2(BURST_WORDS + 1);
    localparam logic [CNT_WIDTH-1:0] BURST_LVL  = CNT_WIDTH'(BURST_WORDS);
    localparam logic [WC_W-1:0]      BURST_LAST = WC_W'(BURST_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_BURST,
        S_RD_OE,
        S_RD_BURST,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [WC_W-1:0] word_cnt_q, word_cnt_d;
    logic            last_dir_wr_q, last_dir_wr_d;
    logic            oe_n_q, wr_n_q, rd_n_q, bus_oe_q, busy_q;

    logic wr_req;
    logic rd_req;

    // A burst may only start when a full burst fits on both sides.
    assign wr_req = en & ~ft_txe_n & (a2f_count >= BURST_LVL);
    assign rd_req = en & ~ft_rxf_n & (f2a_free >= BURST_LVL);

    // FIFO handshakes follow the FT flags within the same cycle so a word
    // refused by the FT601 is never popped or pushed.
    assign a2f_rd_en   = (state_q == S_WR_BURST) & ~ft_txe_n;
    assign f2a_wr_en   = (state_q == S_RD_BURST) & ~ft_rxf_n;
    assign f2a_data    = ft_data_in;
    assign ft_data_out = a2f_data;
    assign ft_be_out   = 4'hF;

    assign ft_oe_n   = oe_n_q;
    assign ft_wr_n   = wr_n_q;
    assign ft_rd_n   = rd_n_q;
    assign ft_bus_oe = bus_oe_q;
    assign busy      = busy_q;
    assign dir_wr    = last_dir_wr_q;

    // Next-state logic: direction choice in IDLE, burst length / flag based exits.
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        last_dir_wr_d = last_dir_wr_q;
        case (state_q)
            S_IDLE: begin
                // On a tie the direction not served last wins.
                if (wr_req && (!rd_req || !last_dir_wr_q)) begin
                    state_d       = S_WR_BURST;
                    last_dir_wr_d = 1'b1;
                    word_cnt_d    = '0;
                end else if (rd_req) begin
                    state_d       = S_RD_OE;
                    last_dir_wr_d = 1'b0;
                    word_cnt_d    = '0;
                end
            end
            S_WR_BURST: begin
                if (ft_txe_n) begin
                    state_d = S_GAP;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == BURST_LAST) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_RD_OE: begin
                state_d = S_RD_BURST;
            end
            S_RD_BURST: begin
                if (ft_rxf_n) begin
                    state_d = S_GAP;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == BURST_LAST) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, burst counter and direction history; reset abandons any burst.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            word_cnt_q    <= '0;
            last_dir_wr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            last_dir_wr_q <= last_dir_wr_d;
        end
    end

    // Strobes are registered decodes of the next state so they are glitch-free at the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oe_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            bus_oe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            oe_n_q   <= !((state_d == S_RD_OE) || (state_d == S_RD_BURST));
            wr_n_q   <= (state_d != S_WR_BURST);
            rd_n_q   <= (state_d != S_RD_BURST);
            bus_oe_q <= (state_d == S_WR_BURST);
            busy_q   <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_ft_bus_arbiter.sv
// tb/tb_ft_bus_arbiter.sv - self-checking bench for ft_bus_arbiter
module tb_ft_bus_arbiter;

    localparam int BW = 32;
    localparam int P_IDLE = 0, P_WR = 1, P_OE = 2, P_RD = 3, P_GAP = 4;

    logic        clk = 1'b0;
    logic        reset_n, en, ft_txe_n, ft_rxf_n;
    logic        ft_oe_n, ft_wr_n, ft_rd_n, ft_bus_oe;
    logic [31:0] ft_data_in, ft_data_out, a2f_data, f2a_data;
    logic [3:0]  ft_be_out;
    logic [7:0]  a2f_count, f2a_free;
    logic        a2f_rd_en, f2a_wr_en, busy, dir_wr;

    always #5 clk = ~clk;

    ft_bus_arbiter #(.FT_DATA_WIDTH(32), .BURST_WORDS(BW), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .ft_txe_n(ft_txe_n), .ft_rxf_n(ft_rxf_n),
        .ft_oe_n(ft_oe_n), .ft_wr_n(ft_wr_n), .ft_rd_n(ft_rd_n),
        .ft_data_in(ft_data_in), .ft_data_out(ft_data_out), .ft_be_out(ft_be_out),
        .ft_bus_oe(ft_bus_oe), .a2f_data(a2f_data), .a2f_count(a2f_count),
        .a2f_rd_en(a2f_rd_en), .f2a_data(f2a_data), .f2a_wr_en(f2a_wr_en),
        .f2a_free(f2a_free), .busy(busy), .dir_wr(dir_wr)
    );

    int checks = 0;
    int errors = 0;

    // A2F FIFO stand-in: head word is a running sequence advanced by the DUT's pops.
    int env_pops = 0;
    bit pop_seen;
    assign a2f_data = 32'hA500_0000 + env_pops;

    // Reference: burst-level scheduler derived from the arbitration rules.
    int m_ph = P_IDLE;
    int m_done = 0;
    bit m_dir_wr = 1'b0;
    int m_pops = 0;

    // Bursts observed on the DUT pins: kind and number of FIFO transfers.
    byte log_k[$];
    int  log_n[$];
    bit  run_w = 0, run_r = 0;
    int  run_wn = 0, run_rn = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("ft_wr_n", ft_wr_n, m_ph != P_WR);
        chk("ft_rd_n", ft_rd_n, m_ph != P_RD);
        chk("ft_oe_n", ft_oe_n, !(m_ph == P_OE || m_ph == P_RD));
        chk("ft_bus_oe", ft_bus_oe, m_ph == P_WR);
        chk("busy", busy, m_ph != P_IDLE);
        chk("dir_wr", dir_wr, m_dir_wr);
        chk("a2f_rd_en", a2f_rd_en, (m_ph == P_WR) && !ft_txe_n);
        chk("f2a_wr_en", f2a_wr_en, (m_ph == P_RD) && !ft_rxf_n);
        if (m_ph == P_WR) begin
            chk("wr_data", ft_data_out, 32'hA500_0000 + m_pops);
            chk("wr_be", ft_be_out, 4'hF);
        end
        if (m_ph == P_RD && !ft_rxf_n) chk("rd_data", f2a_data, ft_data_in);
    endtask

    task automatic observe();
        pop_seen = a2f_rd_en;
        if (!ft_wr_n) begin
            run_w = 1; run_wn += int'(a2f_rd_en);
        end else if (run_w) begin
            log_k.push_back("W"); log_n.push_back(run_wn); run_w = 0; run_wn = 0;
        end
        if (!ft_rd_n) begin
            run_r = 1; run_rn += int'(f2a_wr_en);
        end else if (run_r) begin
            log_k.push_back("R"); log_n.push_back(run_rn); run_r = 0; run_rn = 0;
        end
    endtask

    task automatic model_step();
        bit wr, rd;
        if (!reset_n) begin
            m_ph = P_IDLE; m_dir_wr = 0;
        end else begin
            case (m_ph)
                P_IDLE: begin
                    wr = en && !ft_txe_n && (a2f_count >= BW);
                    rd = en && !ft_rxf_n && (f2a_free >= BW);
                    if (wr && (!rd || !m_dir_wr)) begin
                        m_ph = P_WR; m_dir_wr = 1; m_done = 0;
                    end else if (rd) begin
                        m_ph = P_OE; m_dir_wr = 0; m_done = 0;
                    end
                end
                P_WR: begin
                    if (ft_txe_n) m_ph = P_GAP;
                    else begin
                        m_pops++; m_done++;
                        if (m_done == BW) m_ph = P_GAP;
                    end
                end
                P_OE: m_ph = P_RD;
                P_RD: begin
                    if (ft_rxf_n) m_ph = P_GAP;
                    else begin
                        m_done++;
                        if (m_done == BW) m_ph = P_GAP;
                    end
                end
                default: m_ph = P_IDLE;
            endcase
        end
    endtask

    // One clock: settle, check, log, then take the edge with inputs unchanged.
    task automatic cyc();
        ft_data_in = $urandom();
        #1;
        check_outputs();
        observe();
        @(posedge clk);
        model_step();
        env_pops += int'(pop_seen);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_burst(input int ph, input int words);
        int k = 0;
        while (!(m_ph == ph && m_done == words) && k < 200) begin
            cyc(); k++;
        end
        chk("wait_burst_timeout", k < 200, 1'b1);
    endtask

    task automatic quiesce();
        int k = 0;
        en = 0;
        while (m_ph != P_IDLE && k < 100) begin
            cyc(); k++;
        end
        chk("quiesce_timeout", k < 100, 1'b1);
        run(2);
        log_k.delete(); log_n.delete();
    endtask

    task automatic expect_log(input int idx, input byte kind, input int len);
        chk($sformatf("log%0d_present", idx), log_k.size() > idx, 1'b1);
        if (log_k.size() > idx) begin
            chk($sformatf("log%0d_kind", idx), log_k[idx], kind);
            chk($sformatf("log%0d_len", idx), log_n[idx], len);
        end
    endtask

    initial begin
        reset_n = 0; en = 0; ft_txe_n = 1; ft_rxf_n = 1;
        a2f_count = 0; f2a_free = 0; ft_data_in = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        reset_n = 1;

        // Fairness: both directions always ready, first burst after reset is a write.
        en = 1; ft_txe_n = 0; ft_rxf_n = 0; a2f_count = 40; f2a_free = 64;
        run(160);
        expect_log(0, "W", BW); expect_log(1, "R", BW);
        expect_log(2, "W", BW); expect_log(3, "R", BW);
        quiesce();

        // Back-to-back write bursts.
        en = 1; ft_rxf_n = 1; ft_txe_n = 0; a2f_count = 40;
        run(80);
        expect_log(0, "W", BW); expect_log(1, "W", BW);
        quiesce();

        // Read burst.
        en = 1; a2f_count = 0; ft_rxf_n = 0; f2a_free = 64;
        run(40);
        expect_log(0, "R", BW);
        quiesce();

        // Early write termination after 10 words, then retry.
        en = 1; ft_rxf_n = 1; a2f_count = 40; ft_txe_n = 0;
        wait_burst(P_WR, 10);
        ft_txe_n = 1; run(3); ft_txe_n = 0;
        run(40);
        expect_log(0, "W", 10); expect_log(1, "W", BW);
        quiesce();

        // Early read termination after 5 words, then retry.
        en = 1; ft_txe_n = 1; ft_rxf_n = 0; f2a_free = 64;
        wait_burst(P_RD, 5);
        ft_rxf_n = 1; run(3); ft_rxf_n = 0;
        run(45);
        expect_log(0, "R", 5); expect_log(1, "R", BW);
        quiesce();

        // Thresholds: 31 never starts a burst, 32 does.
        en = 1; ft_txe_n = 0; ft_rxf_n = 1; a2f_count = 31;
        run(40);
        chk("thr_a2f_31", log_k.size(), 0);
        a2f_count = 32;
        run(40);
        expect_log(0, "W", BW);
        quiesce();
        en = 1; a2f_count = 0; ft_txe_n = 1; ft_rxf_n = 0; f2a_free = 31;
        run(40);
        chk("thr_f2a_31", log_k.size(), 0);
        f2a_free = 32;
        run(40);
        expect_log(0, "R", BW);
        quiesce();

        // en dropped mid-burst: burst completes, nothing follows.
        en = 1; ft_rxf_n = 1; ft_txe_n = 0; a2f_count = 40;
        wait_burst(P_WR, 3);
        en = 0;
        run(70);
        chk("en_low_bursts", log_k.size(), 1);
        expect_log(0, "W", BW);
        quiesce();

        // Asynchronous reset in the middle of a write burst.
        en = 1; ft_txe_n = 0; a2f_count = 40;
        wait_burst(P_WR, 5);
        reset_n = 0;
        #1;
        chk("rst_wr_n", ft_wr_n, 1'b1);
        chk("rst_bus_oe", ft_bus_oe, 1'b0);
        chk("rst_rd_en", a2f_rd_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        m_ph = P_IDLE; m_dir_wr = 0;
        run(3);
        reset_n = 1;
        en = 0; run(3);
        expect_log(0, "W", 5);
        log_k.delete(); log_n.delete();
        en = 1;
        run(40);
        expect_log(0, "W", BW);
        quiesce();

        // Randomized traffic against the reference scheduler.
        for (int i = 0; i < 2000; i++) begin
            if (i % 16 == 0) begin
                a2f_count = 8'($urandom_range(28, 40));
                f2a_free  = 8'($urandom_range(28, 40));
            end
            en       = ($urandom_range(0, 15) != 0);
            ft_txe_n = ($urandom_range(0, 7) == 0);
            ft_rxf_n = ($urandom_range(0, 7) == 0);
            cyc();
        end
        quiesce();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ft_bus_arbiter.md
Name: ft_bus_arbiter

Overview:
- Schedules the shared 32-bit FT601 synchronous FIFO bus between two datapaths:
  - AFE-to-FT write path: drains the A2F FIFO toward the host.
  - FT-to-AFE read path: fills the F2A FIFO from the host.
- Runs in the ft_clk domain.
- Issues bursts of at most BURST_WORDS words and alternates direction fairly.
- Drives all FT601 strobes and the bus output-enable, and sits between the FT pins and the two FIFOs inside sdr.

Parameters:
- FT_DATA_WIDTH, 32, FT data bus width.
- BURST_WORDS, 32, maximum words per burst; also the minimum FIFO fill/free needed to start a burst.
- CNT_WIDTH, 8, width of the FIFO level inputs (must hold BURST_WORDS).

Ports:
- clk  in  1  ft_clk domain clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  when low, no new burst starts.
- ft_txe_n  in  1  FT transmit FIFO has space (low active).
- ft_rxf_n  in  1  FT receive FIFO has data (low active).
- ft_oe_n  out  1  FT output enable.
- ft_wr_n  out  1  FT write strobe.
- ft_rd_n  out  1  FT read strobe.
- ft_data_in  in  FT_DATA_WIDTH  sampled ft_data.
- ft_data_out  out  FT_DATA_WIDTH  value driven onto ft_data.
- ft_be_out  out  4  value driven onto ft_be.
- ft_bus_oe  out  1  FPGA drives ft_data/ft_be when high.
- a2f_data  in  FT_DATA_WIDTH  A2F FIFO head word (show-ahead).
- a2f_count  in  CNT_WIDTH  A2F FIFO fill level.
- a2f_rd_en  out  1  pop A2F head.
- f2a_data  out  FT_DATA_WIDTH  word to F2A FIFO.
- f2a_wr_en  out  1  push into F2A.
- f2a_free  in  CNT_WIDTH  F2A FIFO free slots.
- busy  out  1  state is not IDLE.
- dir_wr  out  1  current or last burst was a write.

Behaviour:
- States: IDLE, WR_BURST, RD_OE, RD_BURST, GAP.
- Reset values:
  - Async reset takes effect immediately and may occur mid-burst; the partial burst is abandoned and no FIFO pop or push is generated after reset asserts.
  - State IDLE; ft_oe_n=ft_wr_n=ft_rd_n=1; ft_bus_oe=0; word_cnt=0; last_dir=read; dir_wr=0; busy=0.
- Strobes: ft_oe_n, ft_wr_n, ft_rd_n, ft_bus_oe and busy are registered state decodes.
- Write request: wr_req = en & ~ft_txe_n & (a2f_count >= BURST_WORDS).
- Read request: rd_req = en & ~ft_rxf_n & (f2a_free >= BURST_WORDS).
- IDLE transitions:
  - wr_req only -> WR_BURST.
  - rd_req only -> RD_OE.
  - Both requests -> the direction opposite to last_dir. The first tie after reset goes to write.
  - On entering a burst: last_dir and dir_wr update, and word_cnt clears.
- WR_BURST outputs: ft_bus_oe=1, ft_wr_n=0, ft_data_out=a2f_data (combinational), ft_be_out=4'hF.
- WR_BURST transfer: a word transfers on any edge where ft_wr_n=0 and ft_txe_n=0. a2f_rd_en = (state==WR_BURST) & ~ft_txe_n, combinational; word_cnt increments on the same edge.
- WR_BURST exit: go to GAP after the BURST_WORDS-th transfer, or on the first edge with ft_txe_n=1. A word not transferred stays in the A2F FIFO with no loss or duplication.
- RD_OE: exactly one cycle with ft_oe_n=0 and ft_bus_oe=0 (bus turnaround), then RD_BURST.
- RD_BURST outputs: ft_oe_n=0, ft_rd_n=0, ft_bus_oe=0.
- RD_BURST transfer: f2a_wr_en = (state==RD_BURST) & ~ft_rxf_n, with f2a_data=ft_data_in, both combinational; word_cnt increments on each transfer.
- RD_BURST exit: go to GAP after BURST_WORDS transfers, or on the first edge with ft_rxf_n=1.
- GAP: one cycle with all strobes high and ft_bus_oe=0, then IDLE. Consecutive bursts are always separated by at least 2 idle-strobe cycles (GAP + IDLE).
- en low mid-burst: the current burst completes normally; the block then stays in IDLE until en is high.
- Sizing: word_cnt width is clog2(BURST_WORDS+1). A burst never exceeds BURST_WORDS transfers, so F2A never overflows and A2F never underflows.
- Latency: a request present in IDLE gives the first write strobe 1 cycle later, or the first read strobe 2 cycles later.

Test Plan:
- Write burst:
  - Stimulus: a2f_count=40, ft_txe_n=0, ft_rxf_n=1.
  - Required: exactly 32 consecutive cycles of ft_wr_n=0 with a2f_rd_en high, data equal to the FIFO sequence, be=F; then GAP, then a second burst.
- Read burst:
  - Stimulus: ft_rxf_n=0, f2a_free=64, a2f_count=0.
  - Required: ft_oe_n falls one cycle before ft_rd_n; 32 f2a_wr_en pulses carrying the driven ft_data_in values; ft_bus_oe=0 throughout.
- Early termination:
  - Stimulus: ft_txe_n rises after 10 write transfers.
  - Required: exactly 10 pops, GAP, then a retry when txe_n falls. The same for ft_rxf_n rising after 5 reads: exactly 5 pushes.
- Fairness:
  - Stimulus: both requests continuously asserted.
  - Required: bursts alternate W,R,W,R; the first burst after reset is W.
- Thresholds:
  - Stimulus: a2f_count=31, or f2a_free=31.
  - Required: no burst starts; at 32 a burst starts.
- Reset/enable:
  - Stimulus: reset_n low mid-WR_BURST.
  - Required: strobes go high immediately, no further a2f_rd_en, IDLE after release.
  - Stimulus: en low mid-burst.
  - Required: the burst completes to 32 words, then no new burst starts.
